// File: rtl/comparator_pkg.sv
// Shared types for the multicycle dual-mode comparator: FSM states and the
// three-flag compare result.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one CHUNK-bit slice. The optional MSB
// flip turns a two's-complement top slice into offset binary.
module chunk_compare #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             flip_msb_i,
    output logic             gt_o,
    output logic             lt_o
);

    logic [CHUNK-1:0] flipMask;
    logic [CHUNK-1:0] aAdj;
    logic [CHUNK-1:0] bAdj;

    assign flipMask = CHUNK'(flip_msb_i) << (CHUNK - 1);
    assign aAdj     = a_i ^ flipMask;
    assign bAdj     = b_i ^ flipMask;
    assign gt_o     = (aAdj > bAdj);
    assign lt_o     = (aAdj < bAdj);

endmodule

// File: rtl/multicycle_dual_mode_comparator.sv
// Signed/unsigned magnitude comparator that walks the operands MSB slice
// first, CHUNK bits per cycle, with optional early termination.
module multicycle_dual_mode_comparator #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             agtb_o,
    output logic             aeqb_o,
    output logic             altb_o
);

    import comparator_pkg::*;

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    generate
        if ((CHUNK < 1) || (NUM_CHUNKS < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    cmp_state_t  state_q, state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic             signed_q, signed_d;
    logic [CNT_W-1:0] sliceCnt_q, sliceCnt_d;
    logic             diffFound_q, diffFound_d;
    logic             pendGt_q, pendGt_d;
    logic             pendLt_q, pendLt_d;
    logic             ready_q, ready_d;
    cmp_result_t      result_q, result_d;

    logic sliceGt;
    logic sliceLt;
    logic sliceDiff;
    logic isTopSlice;

    assign isTopSlice = (sliceCnt_q == CNT_W'(NUM_CHUNKS - 1));
    assign sliceDiff  = sliceGt | sliceLt;

    chunk_compare #(
        .CHUNK(CHUNK)
    ) u_chunk_compare (
        .a_i       (aShift_q[WIDTH-1 -: CHUNK]),
        .b_i       (bShift_q[WIDTH-1 -: CHUNK]),
        .flip_msb_i(signed_q & isTopSlice),
        .gt_o      (sliceGt),
        .lt_o      (sliceLt)
    );

    // Operands shift left each compare cycle so the live slice is always at the top.
    always_comb begin
        state_d     = state_q;
        aShift_d    = aShift_q;
        bShift_d    = bShift_q;
        signed_d    = signed_q;
        sliceCnt_d  = sliceCnt_q;
        diffFound_d = diffFound_q;
        pendGt_d    = pendGt_q;
        pendLt_d    = pendLt_q;
        result_d    = result_q;

        case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    aShift_d    = a_i;
                    bShift_d    = b_i;
                    signed_d    = signed_i;
                    sliceCnt_d  = CNT_W'(NUM_CHUNKS - 1);
                    diffFound_d = 1'b0;
                    pendGt_d    = 1'b0;
                    pendLt_d    = 1'b0;
                    state_d     = CMP;
                end
            end
            CMP: begin
                aShift_d   = aShift_q << CHUNK;
                bShift_d   = bShift_q << CHUNK;
                sliceCnt_d = sliceCnt_q - CNT_W'(1);
                if (!diffFound_q && sliceDiff) begin
                    diffFound_d = 1'b1;
                    pendGt_d    = sliceGt;
                    pendLt_d    = sliceLt;
                end
                // Only the first differing slice decides; later slices cannot override it.
                if ((EARLY_EXIT && sliceDiff) || (sliceCnt_q == '0)) begin
                    state_d     = DONE;
                    result_d.gt = diffFound_d & pendGt_d;
                    result_d.lt = diffFound_d & pendLt_d;
                    result_d.eq = ~diffFound_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            aShift_q    <= '0;
            bShift_q    <= '0;
            signed_q    <= 1'b0;
            sliceCnt_q  <= '0;
            diffFound_q <= 1'b0;
            pendGt_q    <= 1'b0;
            pendLt_q    <= 1'b0;
            ready_q     <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            aShift_q    <= aShift_d;
            bShift_q    <= bShift_d;
            signed_q    <= signed_d;
            sliceCnt_q  <= sliceCnt_d;
            diffFound_q <= diffFound_d;
            pendGt_q    <= pendGt_d;
            pendLt_q    <= pendLt_d;
            ready_q     <= ready_d;
            result_q    <= result_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = (state_q == DONE);
    assign agtb_o  = result_q.gt;
    assign aeqb_o  = result_q.eq;
    assign altb_o  = result_q.lt;

endmodule

// File: tb/tb_multicycle_dual_mode_comparator.sv
// Directed bench for the multicycle comparator: vector table on an early-exit
// instance plus hand-written handshake, reset and fixed-latency sequences.
module tb_multicycle_dual_mode_comparator;

    logic        clk;
    logic        rst;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        signedIn;
    logic        validE;
    logic        validF;
    logic        readyE, doneE, gtE, eqE, ltE;
    logic        readyF, doneF, gtF, eqF, ltF;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        gt;
        logic        eq;
        logic        lt;
        int          lat;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    multicycle_dual_mode_comparator #(
        .WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)
    ) dutEarly (
        .clk_i(clk), .rst_i(rst), .a_i(aIn), .b_i(bIn), .signed_i(signedIn),
        .valid_i(validE), .ready_o(readyE), .done_o(doneE),
        .agtb_o(gtE), .aeqb_o(eqE), .altb_o(ltE)
    );

    multicycle_dual_mode_comparator #(
        .WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)
    ) dutFixed (
        .clk_i(clk), .rst_i(rst), .a_i(aIn), .b_i(bIn), .signed_i(signedIn),
        .valid_i(validF), .ready_o(readyF), .done_o(doneF),
        .agtb_o(gtF), .aeqb_o(eqF), .altb_o(ltF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic selReady(input logic fixedSel);
        return fixedSel ? readyF : readyE;
    endfunction

    function automatic logic selDone(input logic fixedSel);
        return fixedSel ? doneF : doneE;
    endfunction

    // Issues one request and returns the number of edges after acceptance
    // until done_o is seen high (-1 on timeout).
    task automatic applyStimulus(input logic fixedSel, input logic [31:0] a,
                                 input logic [31:0] b, input logic sgn, output int lat);
        int guard;
        @(negedge clk);
        aIn      = a;
        bIn      = b;
        signedIn = sgn;
        guard    = 0;
        while (!selReady(fixedSel) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("ready_wait", 0, 1);
        if (fixedSel) validF = 1'b1; else validE = 1'b1;
        @(posedge clk);
        #1;
        validE = 1'b0;
        validF = 1'b0;
        lat    = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (selDone(fixedSel)) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic heldOk;

        vecs[0]  = '{"s_0F_vs_FF",       32'h0000000F, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[1]  = '{"u_0F_vs_FF",       32'h0000000F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[2]  = '{"s_FE_vs_80",       32'hFFFFFFFE, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{"u_FE_vs_80",       32'hFFFFFFFE, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[4]  = '{"s_min_vs_max",     32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[5]  = '{"u_max_vs_min",     32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[6]  = '{"s_eq_80000000",    32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 4};
        vecs[7]  = '{"u_eq_80000000",    32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[8]  = '{"u_last_slice",     32'h12345678, 32'h12345679, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        vecs[9]  = '{"s_second_slice",   32'h12005678, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        vecs[10] = '{"u_third_slice_gt", 32'hAB349900, 32'hAB3411FF, 1'b0, 1'b1, 1'b0, 1'b0, 3};

        rst      = 1'b1;
        aIn      = '0;
        bIn      = '0;
        signedIn = 1'b0;
        validE   = 1'b0;
        validF   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", int'(readyE), 0);
        checkOutput("rst_done",  int'(doneE), 0);
        checkOutput("rst_flags", int'({gtE, eqE, ltE}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_release_ready", int'(readyE), 1);
        checkOutput("rst_release_readyF", int'(readyF), 1);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(1'b0, vecs[i].a, vecs[i].b, vecs[i].sgn, lat);
            checkOutput({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            checkOutput({vecs[i].name, "_gt"}, int'(gtE), int'(vecs[i].gt));
            checkOutput({vecs[i].name, "_eq"}, int'(eqE), int'(vecs[i].eq));
            checkOutput({vecs[i].name, "_lt"}, int'(ltE), int'(vecs[i].lt));
        end

        // Fixed latency: top slice already decides, but all four slices are walked.
        applyStimulus(1'b1, 32'h01000000, 32'h00FFFFFF, 1'b0, lat);
        checkOutput("fixed_lat", lat, 4);
        checkOutput("fixed_flags", int'({gtF, eqF, ltF}), 3'b100);
        applyStimulus(1'b1, 32'hFFFFFF00, 32'h00000001, 1'b1, lat);
        checkOutput("fixed_signed_lat", lat, 4);
        checkOutput("fixed_signed_flags", int'({gtF, eqF, ltF}), 3'b001);

        // Handshake: valid held high with new operands throughout.
        @(negedge clk);
        while (!readyE) @(negedge clk);
        aIn      = 32'h0000000F;
        bIn      = 32'hFFFFFFFF;
        signedIn = 1'b1;
        validE   = 1'b1;
        @(posedge clk);
        #1;
        aIn      = 32'h12345678;
        bIn      = 32'h12345679;
        signedIn = 1'b0;
        checkOutput("hs_ready_cmp", int'(readyE), 0);
        @(posedge clk);
        #1;
        checkOutput("hs_done1", int'(doneE), 1);
        checkOutput("hs_ready_done", int'(readyE), 0);
        checkOutput("hs_flags1", int'({gtE, eqE, ltE}), 3'b100);
        @(posedge clk);
        #1;
        checkOutput("hs_ready_idle", int'(readyE), 1);
        @(posedge clk);
        #1;
        checkOutput("hs_second_accept", int'(readyE), 0);
        heldOk = 1'b1;
        lat    = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (doneE) begin
                lat = k;
                break;
            end
            if ({gtE, eqE, ltE} != 3'b100) heldOk = 1'b0;
        end
        validE = 1'b0;
        checkOutput("hs_flags_held", int'(heldOk), 1);
        checkOutput("hs_lat2", lat, 4);
        checkOutput("hs_flags2", int'({gtE, eqE, ltE}), 3'b001);

        // Reset at E2 of a compare that would otherwise run four slices.
        @(negedge clk);
        while (!readyE) @(negedge clk);
        aIn      = 32'h12345678;
        bIn      = 32'h12345679;
        signedIn = 1'b0;
        validE   = 1'b1;
        @(posedge clk);
        #1;
        validE = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_done", int'(doneE), 0);
        checkOutput("mid_rst_flags", int'({gtE, eqE, ltE}), 0);
        checkOutput("mid_rst_ready", int'(readyE), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_release_ready", int'(readyE), 1);
        heldOk = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (doneE) heldOk = 1'b0;
            @(posedge clk);
            #1;
        end
        checkOutput("mid_rst_no_done", int'(heldOk), 1);
        applyStimulus(1'b0, 32'h0000000F, 32'hFFFFFFFF, 1'b1, lat);
        checkOutput("post_rst_lat", lat, 1);
        checkOutput("post_rst_flags", int'({gtE, eqE, ltE}), 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_dual_mode_comparator.md
Name: multicycle_dual_mode_comparator

Overview:
- Compares two WIDTH-bit operands in signed or unsigned mode, CHUNK bits per cycle, MSB slice first.
- Produces registered greater-than, equal and less-than flags behind a valid/ready request and a one-cycle done pulse.
- With EARLY_EXIT enabled, it finishes as soon as the first differing slice is found.
- Successor to the single-cycle 8-bit dual-mode comparator, for wide datapath compares where a full-width compare would not close timing.

Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK (elaboration-time assertion).
- CHUNK, 8, bits compared per cycle; NUM_CHUNKS = WIDTH/CHUNK, which must be at least 1.
- EARLY_EXIT, 1, 1 = terminate on the first differing slice; 0 = fixed latency of NUM_CHUNKS compare cycles.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- signed_i  in  1  1 = two's-complement compare; 0 = unsigned.
- valid_i  in  1  request.
- ready_o  out  1  block can accept a request.
- done_o  out  1  one-cycle pulse; result flags are valid and updated.
- agtb_o  out  1  A > B.
- aeqb_o  out  1  A == B.
- altb_o  out  1  A < B.

Behaviour:
- Reset (rst_i high at an edge):
  - state becomes IDLE;
  - ready_o, done_o, agtb_o, aeqb_o and altb_o are all 0;
  - operand shift registers are cleared;
  - ready_o is 1 in the first cycle after rst_i deasserts.
- States: IDLE, CMP, DONE.
  - ready_o = (state == IDLE), registered.
  - done_o = (state == DONE).
- IDLE:
  - At an edge where valid_i && ready_o (edge E0), capture a_i, b_i, signed_i and load the slice counter with NUM_CHUNKS-1.
  - Go to CMP.
  - valid_i outside IDLE is ignored, with no queueing.
- CMP: at edge Ek (k = 1..NUM_CHUNKS), compare slice index NUM_CHUNKS-k of the captured operands, unsigned over CHUNK bits.
  - For the top slice only, when the captured signed bit is 1, invert the MSB of both slices before comparing (offset-binary trick).
  - If the slice differs: set the gt/lt sticky and clear eq.
    - If EARLY_EXIT = 1, go to DONE.
    - If EARLY_EXIT = 0, keep the first-difference result and ignore later slices.
  - If the slice is equal and k == NUM_CHUNKS: go to DONE with eq = 1.
- DONE: lasts exactly one cycle.
  - agtb_o, aeqb_o and altb_o are updated at the edge entering DONE.
  - Exactly one flag is high; the flags hold until the next DONE or reset.
  - Return to IDLE at the next edge.
- Latency, from E0 to the cycle in which done_o is high:
  - EARLY_EXIT = 0, or operands equal: done_o is high in the cycle following E_NUM_CHUNKS.
  - EARLY_EXIT = 1 with the first difference at top-first slice position m (1-based): done_o is high in the cycle following E_m.
  - Minimum throughput: one request per NUM_CHUNKS+2 cycles.
- Captured operands and mode are immune to input changes after E0.
- Reset mid-operation aborts the compare: no done_o pulse, and all flags are cleared to 0.
- NUM_CHUNKS = 1 degenerates to a single compare cycle.

Decomposition:
- Shared package comparator_pkg holds:
  - the state typedef cmp_state_t (IDLE, CMP, DONE);
  - the typedef cmp_result_t, a packed struct {gt, eq, lt}.
- One sub-module, chunk_compare: combinational, parameter CHUNK.
  - Inputs: a slice, b slice, flip_msb.
  - Outputs: gt, lt.

Test Plan (WIDTH = 32, CHUNK = 8, EARLY_EXIT = 1 unless noted):
- Signed, A = 0x0000000F, B = 0xFFFFFFFF -> agtb_o = 1 (15 > -1); done_o high in the cycle after E1. Same operands unsigned -> altb_o = 1, also after E1.
- Signed, A = 0xFFFFFFFE, B = 0x80000000 -> agtb_o = 1. Unsigned, same operands -> agtb_o = 1. Signed, A = 0x80000000, B = 0x7FFFFFFF -> altb_o = 1.
- A = B = 0x80000000, both modes -> aeqb_o = 1 only; done_o high in the cycle after E4. A = 0x12345678, B = 0x12345679 unsigned -> altb_o = 1 after E4.
- EARLY_EXIT = 0 instance, A = 0x01000000, B = 0x00FFFFFF unsigned -> agtb_o = 1. done_o is high in the cycle after E4 (not E1), proving the later slices are ignored.
- Handshake: hold valid_i = 1 with new operands throughout the operation. Expect:
  - ready_o = 0 in CMP and DONE;
  - the second request accepted at the first IDLE edge;
  - flags from the first compare held until the second done_o.
- Reset: assert rst_i at E2 of a compare. Expect:
  - no done_o pulse;
  - all flags 0;
  - ready_o = 1 the cycle after rst_i drops;
  - the next request completes correctly.
